// File: rtl/cache_mem_arbiter_pkg.sv
// Shared FSM encoding, parameter defaults and owner encoding for the
// cache/memory arbiter.
package cache_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam int unsigned DEF_WORDS_PER_BLOCK = 8;
  localparam int unsigned DEF_MEM_LATENCY     = 4;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Requester, fill-return and shared-memory signals of the arbiter.
// slave = arbiter view, master = requesters/memory view.
interface cache_mem_arbiter_if
  import cache_mem_pkg::*;
#(
  parameter int unsigned DWIDTH          = 16,
  parameter int unsigned AWIDTH          = 16,
  parameter int unsigned WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK
);
  localparam int unsigned IDXW = idx_width(WORDS_PER_BLOCK);

  logic              i_req;
  logic [AWIDTH-1:0] i_addr;
  logic              d_req;
  logic              d_wr;
  logic [AWIDTH-1:0] d_addr;
  logic [DWIDTH-1:0] d_wdata;
  logic              i_done;
  logic              d_done;
  logic              fill_valid;
  logic [DWIDTH-1:0] fill_data;
  logic [IDXW-1:0]   fill_idx;
  logic              fill_owner;
  logic              mem_enable;
  logic              mem_wr;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_wdata;
  logic [DWIDTH-1:0] mem_rdata;
  logic              mem_valid;

  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_valid,
    output i_done, d_done, fill_valid, fill_data, fill_idx, fill_owner,
           mem_enable, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_valid,
    input  i_done, d_done, fill_valid, fill_data, fill_idx, fill_owner,
           mem_enable, mem_wr, mem_addr, mem_wdata
  );

endinterface

// File: rtl/cache_mem_arbiter_arb_pick2.sv
// Two-requester grant picker: a lone request wins outright, a tie goes to
// the requester that was not granted last (index 0 = I, 1 = D).
module arb_pick2
  import cache_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (&req) gnt = (last_gnt == OWNER_D) ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates I-cache fills and D-cache fills/writes onto one multi-cycle memory.
// Define ARB_RR_EN for round-robin tie-breaking; default gives D-cache priority.
module cache_mem_arbiter
  import cache_mem_pkg::*;
#(
  parameter int unsigned DWIDTH          = 16,
  parameter int unsigned AWIDTH          = 16,
  parameter int unsigned WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
  parameter int unsigned MEM_LATENCY     = DEF_MEM_LATENCY
) (
  input logic                clk,
  input logic                rst,
  cache_mem_arbiter_if.slave bus
);

  localparam int unsigned       IDXW     = idx_width(WORDS_PER_BLOCK);
  localparam int unsigned       CNTW     = IDXW + 1;
  localparam int unsigned       AGEW     = $clog2(WORDS_PER_BLOCK + MEM_LATENCY + 1);
  localparam logic [AWIDTH-1:0] BLK_MASK = AWIDTH'(2 * WORDS_PER_BLOCK - 1);

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic [CNTW-1:0]   issue_q, issue_d;
  logic [IDXW-1:0]   rcv_q, rcv_d;
  logic [AGEW-1:0]   age_q, age_d;
  logic [1:0]        gnt;
  logic              last_gnt;

  arb_pick2 u_pick (
    .req      ({bus.d_req, bus.i_req}),
    .last_gnt (last_gnt),
    .gnt      (gnt)
  );

`ifdef ARB_RR_EN
  logic last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && (|gnt)) last_d = gnt[1];
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= OWNER_D;
    else     last_q <= last_d;
  end

  assign last_gnt = last_q;
`else
  // A permanent "I served last" makes every tie go to the D-cache.
  assign last_gnt = OWNER_I;
`endif

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    issue_d        = issue_q;
    rcv_d          = rcv_q;
    age_d          = '0;
    bus.i_done     = 1'b0;
    bus.d_done     = 1'b0;
    bus.fill_valid = 1'b0;
    bus.fill_data  = '0;
    bus.fill_idx   = '0;
    bus.fill_owner = owner_q;
    bus.mem_enable = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    unique case (state_q)
      IDLE: begin
        if (|gnt) begin
          owner_d = gnt[1] ? OWNER_D : OWNER_I;
          addr_d  = gnt[1] ? bus.d_addr : bus.i_addr;
          wdata_d = bus.d_wdata;
          issue_d = '0;
          rcv_d   = '0;
          state_d = (gnt[1] && bus.d_wr) ? WRITE : FILL;
        end
      end
      FILL: begin
        age_d = age_q + 1'b1;
        if (issue_q < CNTW'(WORDS_PER_BLOCK)) begin
          bus.mem_enable = 1'b1;
          bus.mem_addr   = (addr_q & ~BLK_MASK) + (AWIDTH'(issue_q) << 1);
          issue_d        = issue_q + 1'b1;
        end
        if (bus.mem_valid) begin
          bus.fill_valid = 1'b1;
          bus.fill_data  = bus.mem_rdata;
          bus.fill_idx   = rcv_q;
          if (rcv_q == IDXW'(WORDS_PER_BLOCK - 1)) begin
            bus.i_done = (owner_q == OWNER_I);
            bus.d_done = (owner_q == OWNER_D);
            state_d    = IDLE;
          end else begin
            rcv_d = rcv_q + 1'b1;
          end
        end
      end
      WRITE: begin
        bus.mem_enable = 1'b1;
        bus.mem_wr     = 1'b1;
        bus.mem_addr   = {addr_q[AWIDTH-1:1], 1'b0};
        bus.mem_wdata  = wdata_q;
        bus.d_done     = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWNER_I;
      addr_q  <= '0;
      wdata_q <= '0;
      issue_q <= '0;
      rcv_q   <= '0;
      age_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      issue_q <= issue_d;
      rcv_q   <= rcv_d;
      age_q   <= age_d;
    end
  end

  // Memory contract: a block fill never outlives its issue window plus MEM_LATENCY.
  assert property (@(posedge clk) disable iff (rst)
    (state_q == FILL) |-> (age_q <= AGEW'(WORDS_PER_BLOCK + MEM_LATENCY - 1)));

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed self-checking bench for cache_mem_arbiter with a fixed-latency
// memory model (4 cycles, default contents 0x4000 + byte address).
module tb_cache_mem_arbiter;
  import cache_mem_pkg::*;

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
    logic        w;
    int          c;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   drop_i = 1'b1;
  logic first_own;
  ev_t  issue_q[$];
  ev_t  fill_q[$];
  ev_t  done_q[$];

  logic [3:0]  pv;
  logic [15:0] pd [4];
  logic [15:0] wmem [int unsigned];

  cache_mem_arbiter_if #(.DWIDTH(16), .AWIDTH(16), .WORDS_PER_BLOCK(8)) bus ();

  cache_mem_arbiter #(
    .DWIDTH(16), .AWIDTH(16), .WORDS_PER_BLOCK(8), .MEM_LATENCY(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_read(input logic [15:0] a);
    logic [15:0] wa;
    int unsigned key;
    wa  = {a[15:1], 1'b0};
    key = int'(wa);
    return wmem.exists(key) ? wmem[key] : 16'h4000 + wa;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      pv <= '0;
    end else begin
      pv    <= {pv[2:0], bus.mem_enable & ~bus.mem_wr};
      pd[0] <= mem_read(bus.mem_addr);
      pd[1] <= pd[0];
      pd[2] <= pd[1];
      pd[3] <= pd[2];
      if (bus.mem_enable && bus.mem_wr) wmem[int'({bus.mem_addr[15:1], 1'b0})] = bus.mem_wdata;
    end
  end

  assign bus.mem_valid = pv[3];
  assign bus.mem_rdata = pd[3];

  always @(negedge clk) begin
    cyc++;
    if (bus.mem_enable) issue_q.push_back('{a: bus.mem_addr, d: bus.mem_wdata, w: bus.mem_wr, c: cyc});
    if (bus.fill_valid) fill_q.push_back('{a: 16'(bus.fill_idx), d: bus.fill_data, w: bus.fill_owner, c: cyc});
    if (bus.i_done) done_q.push_back('{a: 16'h0, d: 16'h0, w: 1'b0, c: cyc});
    if (bus.d_done) done_q.push_back('{a: 16'h0, d: 16'h0, w: 1'b1, c: cyc});
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic clear_logs();
    issue_q.delete();
    fill_q.delete();
    done_q.delete();
  endtask

  task automatic run(input int n_done, input int budget);
    int got = 0;
    for (int c = 0; c < budget && got < n_done; c++) begin
      @(negedge clk);
      if (bus.i_done) begin got++; if (drop_i) bus.i_req = 1'b0; end
      if (bus.d_done) begin got++; bus.d_req = 1'b0; end
    end
    #1;
    check("done_count", got, n_done);
  endtask

  task automatic check_block(input string tag, input int first, input logic [15:0] base,
                             input logic own, input int dn);
    bit ok;
    ok = (issue_q.size() >= first + 8) && (fill_q.size() >= first + 8) && (done_q.size() > dn);
    check({tag, "_logs"}, ok, 1);
    if (!ok) return;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("%s_addr%0d", tag, k), issue_q[first+k].a, base + 16'(2 * k));
      check($sformatf("%s_rd%0d", tag, k), issue_q[first+k].w, 0);
      check($sformatf("%s_idx%0d", tag, k), fill_q[first+k].a, k);
      check($sformatf("%s_data%0d", tag, k), fill_q[first+k].d, 16'h4000 + base + 16'(2 * k));
      check($sformatf("%s_own%0d", tag, k), fill_q[first+k].w, own);
    end
    check({tag, "_done_own"}, done_q[dn].w, own);
    check({tag, "_done_last"}, done_q[dn].c, fill_q[first+7].c);
    check({tag, "_done_lat"}, done_q[dn].c - issue_q[first].c, 11);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_wr    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
`ifdef ARB_RR_EN
    first_own = OWNER_I;
`else
    first_own = OWNER_D;
`endif

    // reset state
    repeat (3) @(negedge clk);
    check("rst_mem_en", bus.mem_enable, 0);
    check("rst_mem_wr", bus.mem_wr, 0);
    check("rst_fill_v", bus.fill_valid, 0);
    check("rst_dones", {bus.i_done, bus.d_done}, 0);
    check("rst_owner", bus.fill_owner, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    rst = 1'b0;

    // I-cache fill from a mid-block miss address
    clear_logs();
    bus.i_addr = 16'h0036;
    bus.i_req  = 1'b1;
    run(1, 60);
    check("t1_nissue", issue_q.size(), 8);
    check_block("t1", 0, 16'h0030, OWNER_I, 0);

    // D-cache single-word write, then read back its block
    clear_logs();
    bus.d_wr    = 1'b1;
    bus.d_addr  = 16'h1235;
    bus.d_wdata = 16'hBEEF;
    bus.d_req   = 1'b1;
    run(1, 20);
    check("t2_nissue", issue_q.size(), 1);
    check("t2_waddr", issue_q[0].a, 16'h1234);
    check("t2_wr", issue_q[0].w, 1);
    check("t2_wdata", issue_q[0].d, 16'hBEEF);
    check("t2_done_own", done_q[0].w, OWNER_D);
    check("t2_done_cyc", done_q[0].c, issue_q[0].c);
    clear_logs();
    bus.d_wr   = 1'b0;
    bus.d_addr = 16'h1230;
    bus.d_req  = 1'b1;
    run(1, 60);
    check("t2_rb_idx2", fill_q[2].a, 2);
    check("t2_rb_data2", fill_q[2].d, 16'hBEEF);
    check("t2_rb_data3", fill_q[3].d, 16'h5236);
    check("t2_rb_own", done_q[0].w, OWNER_D);

    // two simultaneous fill ties in a row
    for (int rep = 0; rep < 2; rep++) begin
      clear_logs();
      bus.i_addr = 16'h0100;
      bus.d_addr = 16'h0200;
      bus.d_wr   = 1'b0;
      bus.i_req  = 1'b1;
      bus.d_req  = 1'b1;
      run(2, 100);
      check_block($sformatf("t3r%0da", rep), 0, (first_own == OWNER_D) ? 16'h0200 : 16'h0100, first_own, 0);
      check_block($sformatf("t3r%0db", rep), 8, (first_own == OWNER_D) ? 16'h0100 : 16'h0200, ~first_own, 1);
      check($sformatf("t3r%0d_gap", rep), issue_q[8].c, done_q[0].c + 2);
    end

    // D request arrives mid I-fill; I drops request and changes address
    clear_logs();
    bus.i_addr = 16'h0040;
    bus.i_req  = 1'b1;
    repeat (3) @(negedge clk);
    bus.d_addr = 16'h0080;
    bus.d_req  = 1'b1;
    repeat (2) @(negedge clk);
    bus.i_req  = 1'b0;
    bus.i_addr = 16'h7777;
    run(2, 100);
    check_block("t4i", 0, 16'h0040, OWNER_I, 0);
    check_block("t4d", 8, 16'h0080, OWNER_D, 1);
    check("t4_gap", issue_q[8].c, done_q[0].c + 2);

    // reset at FILL cycle 6 aborts the fill
    clear_logs();
    bus.i_addr = 16'h0300;
    bus.i_req  = 1'b1;
    for (int c = 0; c < 20 && issue_q.size() == 0; c++) begin
      @(negedge clk);
      #1;
    end
    check("t5_started", issue_q.size(), 1);
    repeat (6) @(negedge clk);
    rst       = 1'b1;
    bus.i_req = 1'b0;
    @(posedge clk);
    #1;
    check("t5_pre_fills", fill_q.size(), 3);
    check("t5_rst_fill_v", bus.fill_valid, 0);
    check("t5_rst_mem_en", bus.mem_enable, 0);
    check("t5_rst_done", bus.i_done, 0);
    clear_logs();
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    check("t5_quiet_fill", fill_q.size(), 0);
    check("t5_quiet_done", done_q.size(), 0);
    check("t5_quiet_issue", issue_q.size(), 0);
    bus.i_addr = 16'h0302;
    bus.i_req  = 1'b1;
    run(1, 60);
    check_block("t5", 0, 16'h0300, OWNER_I, 0);

    // request still held after done is served again
    clear_logs();
    drop_i     = 1'b0;
    bus.i_addr = 16'h0500;
    bus.i_req  = 1'b1;
    run(1, 60);
    drop_i = 1'b1;
    run(1, 60);
    check("t6_nissue", issue_q.size(), 16);
    check_block("t6b", 8, 16'h0500, OWNER_I, 1);
    check("t6_gap", issue_q[8].c, done_q[0].c + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 16, memory data width.
REQ-002 The block SHALL have parameter AWIDTH, default 16, byte-address width.
REQ-003 The block SHALL have parameter WORDS_PER_BLOCK, default 8, 16-bit words per cache block fill.
REQ-004 The block SHALL have parameter MEM_LATENCY, default 4, cycles from memory read issue to data_valid.
REQ-005 clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-006 i_req in 1 I-cache fill request (level, held until i_done); i_addr in AWIDTH miss address.
REQ-007 d_req in 1 D-cache request (level, held until d_done); d_wr in 1 1=single-word write, 0=block fill; d_addr in AWIDTH; d_wdata in DWIDTH.
REQ-008 i_done/d_done out 1 one-cycle completion pulse per requester.
REQ-009 fill_valid out 1 fill word present; fill_data out DWIDTH; fill_idx out log2(WORDS_PER_BLOCK) word index in block; fill_owner out 1 (0=I,1=D).
REQ-010 mem_enable out 1; mem_wr out 1; mem_addr out AWIDTH; mem_wdata out DWIDTH; mem_rdata in DWIDTH; mem_valid in 1 -- connect to the shared multi-cycle memory.

Function
REQ-011 FSM states SHALL be IDLE, FILL, WRITE.
REQ-012 IDLE: if any request pending, SHALL grant one (per REQ-023) and move to FILL (fill) or WRITE (d_req&d_wr) next cycle; owner latched at grant.
REQ-013 Fill base address SHALL be the latched address with low log2(2*WORDS_PER_BLOCK) bits cleared.
REQ-014 FILL: issue counter SHALL drive mem_enable=1, mem_wr=0, mem_addr=base+2*k for k=0..WORDS_PER_BLOCK-1 on consecutive FILL cycles, then mem_enable=0.
REQ-015 FILL: each mem_valid SHALL produce fill_valid=1, fill_data=mem_rdata, fill_idx=receive count, same cycle (combinational pass-through); receive count increments.
REQ-016 Last word (receive count WORDS_PER_BLOCK-1 with mem_valid) SHALL pulse owner's done in that same cycle and return to IDLE next cycle; with defaults, done occurs 12 cycles after FILL entry (FILL cycles 0..11).
REQ-017 WRITE: SHALL last exactly one cycle with mem_enable=1, mem_wr=1, mem_addr=d_addr with bit0 forced 0, mem_wdata=d_wdata, d_done=1; return to IDLE next.
REQ-018 Outside FILL/WRITE, mem_enable, mem_wr, fill_valid, done outputs SHALL be 0; mem_valid in IDLE/WRITE SHALL be ignored.
REQ-019 Request deassertion or address change mid-transaction SHALL be ignored; transaction completes with latched values.
REQ-020 A requester still asserting req in the cycle after its done SHALL be treated as a new request.

Reset
REQ-021 rst SHALL force IDLE, counters and owner to 0, all outputs 0 next cycle; reset mid-FILL SHALL abort without done pulse.
REQ-022 rst SHALL be shared with the memory so in-flight read data is discarded.

Configuration
REQ-023 Without ARB_RR_EN, simultaneous requests SHALL grant D-cache first; with ARB_RR_EN defined, SHALL grant the requester not served last (initial last=D after reset, so I wins first tie).

Structure
REQ-024 Package cache_mem_pkg SHALL hold the state enum, WORDS_PER_BLOCK/MEM_LATENCY defaults, and owner encoding constants.
REQ-025 Grant selection SHALL be a sub-module arb_pick2 (two requests, last-grant input, one-hot grant out).

Verification
REQ-026 i_req, i_addr=0x0036 -> mem reads 0x0030..0x003E over 8 cycles; fill_idx 0..7; i_done with idx 7; fill_owner=0.
REQ-027 d_req, d_wr=1, d_addr=0x1235, d_wdata=0xBEEF -> one cycle mem_wr=1, mem_addr=0x1234; d_done same cycle; read-back fill returns 0xBEEF at idx 2.
REQ-028 i_req and d_req (fill) same cycle -> fixed: D fill then I fill; ARB_RR_EN: I first, then D, then alternate on repeated ties.
REQ-029 rst at FILL cycle 6 -> no done, no fill_valid after reset; following request fills fully and correctly.
REQ-030 d_req during I fill -> waits; granted IDLE cycle after i_done; i_req dropped mid-fill -> fill still completes with i_done.
